// File: rtl/clkdiv_lock_monitor.sv
// Divided-clock lock monitor: samples divclk_in as data in the hclkin domain,
// measures its period and qualifies it against DIV_RATIO before asserting locked.
module clkdiv_lock_monitor #(
   parameter int DIV_RATIO  = 8,
   parameter int TOL        = 0,
   parameter int LOCK_COUNT = 4,
   parameter int CNT_W      = 8
) (
   input  logic             hclkin,
   input  logic             resetn,
   input  logic             enable,
   input  logic             divclk_in,
   output logic             locked,
   output logic             err,
   output logic             timeout,
   output logic [CNT_W-1:0] period,
   output logic [7:0]       good_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2,
      LOCKED  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(4 * DIV_RATIO);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [31:0]      PER_LO      = (DIV_RATIO > TOL) ? 32'(DIV_RATIO - TOL) : 32'd0;
   localparam logic [31:0]      PER_HI      = 32'(DIV_RATIO + TOL);
   localparam logic [7:0]       LOCK_CNT8   = 8'(LOCK_COUNT);

   logic             sync1, sync2, prev, rise;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_d;
   logic [7:0]       good_d, good_inc;
   logic             err_d, timeout_d, locked_d;
   logic             in_window, at_limit;
   logic [31:0]      cnt_ext;

   // divclk_in is asynchronous data here: two-flop synchronizer, then a
   // registered rising-edge detect.
   always_ff @(posedge hclkin or negedge resetn) begin
      if (!resetn) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         rise  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every stage samples the previous-cycle value of its source.
         sync1 <= divclk_in;
         sync2 <= sync1;
         prev  <= sync2;
         rise  <= sync2 & ~prev;
      end
   end

   assign cnt_ext   = 32'(cnt_q);
   assign in_window = (cnt_ext >= PER_LO) && (cnt_ext <= PER_HI);
   assign at_limit  = (cnt_q == TIMEOUT_LIM);
   assign good_inc  = (good_cnt == 8'hFF) ? good_cnt : good_cnt + 8'd1;

   always_ff @(posedge hclkin or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A rise in the same cycle as the timeout threshold is a measurement, not a timeout.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ACQUIRE;
            end
            ACQUIRE: begin
               if (rise) begin
                  state_d = TRACK;
               end
            end
            TRACK: begin
               if (rise) begin
                  if (in_window && (good_inc >= LOCK_CNT8)) begin
                     state_d = LOCKED;
                  end
               end else if (at_limit) begin
                  state_d = ACQUIRE;
               end
            end
            LOCKED: begin
               if (rise) begin
                  if (!in_window) begin
                     state_d = TRACK;
                  end
               end else if (at_limit) begin
                  state_d = ACQUIRE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // The first rise in ACQUIRE only restarts the counter; the partial period before it is discarded.
   always_comb begin
      cnt_d     = cnt_q;
      period_d  = period;
      good_d    = good_cnt;
      err_d     = err;
      timeout_d = timeout;
      if (!enable || (state_q == IDLE)) begin
         cnt_d     = '0;
         good_d    = '0;
         err_d     = 1'b0;
         timeout_d = 1'b0;
      end else if (rise) begin
         cnt_d = CNT_ONE;
         if (state_q == ACQUIRE) begin
            good_d = '0;
         end else begin
            period_d = cnt_q;
            if (in_window) begin
               good_d = good_inc;
            end else begin
               good_d = '0;
               err_d  = 1'b1;
            end
         end
      end else if (at_limit) begin
         cnt_d     = '0;
         good_d    = '0;
         err_d     = 1'b1;
         timeout_d = 1'b1;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // locked follows the next state so it rises in the cycle the FSM enters LOCKED.
   assign locked_d = (state_d == LOCKED);

   always_ff @(posedge hclkin or negedge resetn) begin
      if (!resetn) begin
         cnt_q    <= '0;
         period   <= '0;
         good_cnt <= '0;
         err      <= 1'b0;
         timeout  <= 1'b0;
         locked   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         period   <= period_d;
         good_cnt <= good_d;
         err      <= err_d;
         timeout  <= timeout_d;
         locked   <= locked_d;
      end
   end

endmodule

// File: tb/tb_clkdiv_lock_monitor.sv
// Self-checking bench for clkdiv_lock_monitor: TOL=0 and TOL=1 instances share
// one stimulus and are compared against an edge-gap reference model.
module tb_clkdiv_lock_monitor;

   localparam int DIV  = 8;
   localparam int LIM  = 4 * DIV;
   localparam int LOCK = 4;
   localparam int M_ACQ = 0;
   localparam int M_TRK = 1;
   localparam int M_LCK = 2;

   logic       hclkin    = 1'b0;
   logic       resetn    = 1'b0;
   logic       enable    = 1'b0;
   logic       divclk_in = 1'b0;
   logic       lk [2];
   logic       er [2];
   logic       to [2];
   logic [7:0] per [2];
   logic [7:0] gc [2];

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: one entry per instance, advanced once per divclk rising edge.
   int m_st [2];
   int m_good [2];
   int m_per [2];
   int m_lk [2];
   int m_err [2];
   int m_to [2];
   int m_tol [2] = '{0, 1};

   typedef struct {
      int low;
      int e_per;
      int e_good;
      int e_lk;
      int e_err;
   } vec_t;

   vec_t tbl [10];

   clkdiv_lock_monitor #(.DIV_RATIO(DIV), .TOL(0), .LOCK_COUNT(LOCK), .CNT_W(8)) dut0 (
      .hclkin    (hclkin),
      .resetn    (resetn),
      .enable    (enable),
      .divclk_in (divclk_in),
      .locked    (lk[0]),
      .err       (er[0]),
      .timeout   (to[0]),
      .period    (per[0]),
      .good_cnt  (gc[0])
   );

   clkdiv_lock_monitor #(.DIV_RATIO(DIV), .TOL(1), .LOCK_COUNT(LOCK), .CNT_W(8)) dut1 (
      .hclkin    (hclkin),
      .resetn    (resetn),
      .enable    (enable),
      .divclk_in (divclk_in),
      .locked    (lk[1]),
      .err       (er[1]),
      .timeout   (to[1]),
      .period    (per[1]),
      .good_cnt  (gc[1])
   );

   always #5 hclkin = ~hclkin;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i]   = M_ACQ;
         m_good[i] = 0;
         m_per[i]  = 0;
         m_lk[i]   = 0;
         m_err[i]  = 0;
         m_to[i]   = 0;
      end
   endtask

   task automatic model_idle();
      for (int i = 0; i < 2; i++) begin
         m_st[i]   = M_ACQ;
         m_good[i] = 0;
         m_lk[i]   = 0;
         m_err[i]  = 0;
         m_to[i]   = 0;
      end
   endtask

   // gap = hclkin cycles since the previous divclk rising edge.
   task automatic model_rise(input int gap);
      int d;
      for (int i = 0; i < 2; i++) begin
         if ((m_st[i] != M_ACQ) && (gap > LIM)) begin
            m_to[i]   = 1;
            m_err[i]  = 1;
            m_lk[i]   = 0;
            m_good[i] = 0;
            m_st[i]   = M_ACQ;
         end
         if (m_st[i] == M_ACQ) begin
            m_st[i]   = M_TRK;
            m_good[i] = 0;
         end else begin
            m_per[i] = gap;
            d = (gap > DIV) ? gap - DIV : DIV - gap;
            if (d <= m_tol[i]) begin
               m_good[i] = (m_good[i] < 255) ? m_good[i] + 1 : 255;
               if (m_good[i] >= LOCK) begin
                  m_st[i] = M_LCK;
                  m_lk[i] = 1;
               end
            end else begin
               m_err[i]  = 1;
               m_good[i] = 0;
               m_lk[i]   = 0;
               m_st[i]   = M_TRK;
            end
         end
      end
   endtask

   task automatic model_check(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s dut%0d period", tag, i), 32'(per[i]), m_per[i]);
         check($sformatf("%s dut%0d good_cnt", tag, i), 32'(gc[i]), m_good[i]);
         check($sformatf("%s dut%0d locked", tag, i), 32'(lk[i]), m_lk[i]);
         check($sformatf("%s dut%0d err", tag, i), 32'(er[i]), m_err[i]);
         check($sformatf("%s dut%0d timeout", tag, i), 32'(to[i]), m_to[i]);
      end
   endtask

   // Called on a negedge; the edge reaches the outputs 4 negedges later.
   task automatic rise_now(input int gap, input string tag);
      divclk_in = 1'b1;
      repeat (4) @(negedge hclkin);
      model_rise(gap);
      model_check(tag);
   endtask

   task automatic do_rise(input int low, input string tag);
      divclk_in = 1'b0;
      repeat (low) @(negedge hclkin);
      rise_now(low + 4, tag);
   endtask

   task automatic enable_pulse();
      enable = 1'b0;
      @(negedge hclkin);
      model_idle();
      model_check("enable_off");
      repeat (2) @(negedge hclkin);
      enable = 1'b1;
   endtask

   task automatic relock(input string tag);
      for (int k = 0; k < LOCK; k++) begin
         do_rise(4, tag);
      end
   endtask

   initial begin
      // low cycles, period, good_cnt, locked, err for the TOL=0 instance
      tbl[0] = '{4, 0, 0, 0, 0};
      tbl[1] = '{4, 8, 1, 0, 0};
      tbl[2] = '{4, 8, 2, 0, 0};
      tbl[3] = '{4, 8, 3, 0, 0};
      tbl[4] = '{4, 8, 4, 1, 0};
      tbl[5] = '{6, 10, 0, 0, 1};
      tbl[6] = '{4, 8, 1, 0, 1};
      tbl[7] = '{4, 8, 2, 0, 1};
      tbl[8] = '{4, 8, 3, 0, 1};
      tbl[9] = '{4, 8, 4, 1, 1};

      model_reset();
      repeat (3) @(negedge hclkin);
      model_check("reset");
      resetn = 1'b1;
      @(negedge hclkin);
      enable = 1'b1;

      // Nominal lock, then one bad period and recovery.
      for (int k = 0; k < 10; k++) begin
         do_rise(tbl[k].low, $sformatf("tbl%0d", k));
         check($sformatf("tbl%0d period", k), 32'(per[0]), tbl[k].e_per);
         check($sformatf("tbl%0d good_cnt", k), 32'(gc[0]), tbl[k].e_good);
         check($sformatf("tbl%0d locked", k), 32'(lk[0]), tbl[k].e_lk);
         check($sformatf("tbl%0d err", k), 32'(er[0]), tbl[k].e_err);
      end

      // Tolerance: periods 7/9 lock TOL=1 but not TOL=0; then a period of 6.
      enable_pulse();
      do_rise(4, "tol_acq");
      do_rise(3, "tol7a");
      do_rise(5, "tol9a");
      do_rise(3, "tol7b");
      check("tol unlocked before 4th", 32'(lk[1]), 0);
      do_rise(5, "tol9b");
      check("tol locked", 32'(lk[1]), 1);
      check("tol err clear", 32'(er[1]), 0);
      check("tol0 err", 32'(er[0]), 1);
      check("tol0 unlocked", 32'(lk[0]), 0);
      do_rise(2, "tol6");
      check("tol6 err", 32'(er[1]), 1);
      check("tol6 locked", 32'(lk[1]), 0);
      check("tol6 period", 32'(per[1]), 6);
      relock("tol_relock");

      // Stopped clock: timeout lands exactly 32 cycles after the last reload.
      divclk_in = 1'b0;
      repeat (31) @(negedge hclkin);
      check("stop timeout at 31", 32'(to[0]), 0);
      check("stop locked at 31", 32'(lk[0]), 1);
      @(negedge hclkin);
      check("stop timeout at 32", 32'(to[0]), 1);
      check("stop err at 32", 32'(er[0]), 1);
      check("stop locked at 32", 32'(lk[0]), 0);
      check("stop good_cnt at 32", 32'(gc[0]), 0);
      check("stop timeout tol1", 32'(to[1]), 1);
      repeat (9) @(negedge hclkin);
      rise_now(45, "stop_restart");
      relock("stop_relock");
      check("stop relocked", 32'(lk[0]), 1);
      check("stop timeout sticky", 32'(to[0]), 1);

      // enable low while LOCKED.
      enable_pulse();
      check("enable_off locked", 32'(lk[0]), 0);
      check("enable_off good_cnt", 32'(gc[0]), 0);
      check("enable_off period held", 32'(per[0]), 8);
      do_rise(4, "en_acq");
      relock("en_relock");

      // Edge exactly at the threshold is measured; one cycle later is a timeout.
      do_rise(28, "gap32");
      check("gap32 period", 32'(per[0]), 32);
      check("gap32 err", 32'(er[0]), 1);
      check("gap32 timeout", 32'(to[0]), 0);
      check("gap32 locked", 32'(lk[0]), 0);
      do_rise(4, "gap32_next");
      check("gap32 stays tracking", 32'(gc[0]), 1);
      do_rise(29, "gap33");
      check("gap33 timeout", 32'(to[0]), 1);
      check("gap33 period held", 32'(per[0]), 8);
      check("gap33 good_cnt", 32'(gc[0]), 0);

      // One-cycle reset pulse mid-TRACK.
      do_rise(4, "pre_reset");
      divclk_in = 1'b0;
      @(negedge hclkin);
      resetn = 1'b0;
      #1;
      model_reset();
      model_check("async_reset");
      @(negedge hclkin);
      resetn = 1'b1;
      do_rise(4, "rst_acq");
      do_rise(4, "rst1");
      do_rise(4, "rst2");
      do_rise(4, "rst3");
      check("rst not yet locked", 32'(lk[0]), 0);
      do_rise(4, "rst4");
      check("rst relocked", 32'(lk[0]), 1);

      // good_cnt saturates at 255 while LOCKED.
      for (int k = 0; k < 251; k++) begin
         do_rise(4, "sat");
      end
      check("sat good_cnt 255", 32'(gc[0]), 255);
      do_rise(4, "sat_hold");
      check("sat good_cnt hold", 32'(gc[0]), 255);
      check("sat locked", 32'(lk[0]), 1);

      // Randomized periods, timeouts and enable drops.
      for (int k = 0; k < 200; k++) begin
         int r;
         r = $urandom_range(99);
         if (r < 5) begin
            enable_pulse();
            do_rise($urandom_range(20, 1), "rnd_acq");
         end else if (r < 75) begin
            do_rise($urandom_range(5, 3), "rnd_near");
         end else if (r < 92) begin
            do_rise($urandom_range(28, 1), "rnd_wide");
         end else begin
            do_rise($urandom_range(34, 29), "rnd_edge");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/clkdiv_lock_monitor.md
Name: clkdiv_lock_monitor

Overview:
- Consumer/checker for the hard-macro divided clock: samples the divided clock as data in the fast (hclkin) domain, measures its period in hclkin cycles, and qualifies it against the expected divide ratio.
- Drives `locked` to release downstream slow-domain logic (serializer/deserializer gearboxes) only after a stable divided clock is confirmed.
- Flags period errors and a missing clock.
- Sits beside the divider instance; its `locked` output gates resets of the divided-clock domain.

Parameters:
DIV_RATIO, 8, expected hclkin cycles per divided-clock period (legal 2..64)
TOL, 0, allowed +/- deviation in measured period, in hclkin cycles
LOCK_COUNT, 4, consecutive in-tolerance periods required to assert locked (1..255)
CNT_W, 8, width of period counter and period output; must hold 4*DIV_RATIO

Ports:
hclkin  input  1  fast clock, sole clock of the block
resetn  input  1  asynchronous active-low reset
enable  input  1  monitor enable; 0 forces IDLE
divclk_in  input  1  divided clock, treated as asynchronous data
locked  output  1  divided clock qualified stable
err  output  1  sticky error: bad period or timeout since last enable rise
timeout  output  1  sticky: no rising edge within 4*DIV_RATIO cycles
period  output  CNT_W  last measured period in hclkin cycles
good_cnt  output  8  current count of consecutive good periods (saturating at 255)

Behaviour:
Reset (resetn=0, asynchronous):
- Synchronizer flops = 0; state = IDLE.
- locked = 0, err = 0, timeout = 0, period = 0, good_cnt = 0, counter = 0.

Input path:
- Two-flop synchronizer s1->s2, then prev register.
- Edge detect: rise = s2 & ~prev, registered.
- An edge on divclk_in produces rise at most 4 hclkin cycles later.

Counter:
- Increments every cycle in ACQUIRE/TRACK/LOCKED and saturates at all-ones.
- On rise, the counter loads 1 and the old value is the measured period.
- A period is good when |measured - DIV_RATIO| <= TOL.

States:
- IDLE:
  - All outputs are held at their reset values except period, which holds its last value.
  - Moves to ACQUIRE when enable=1.
  - On entering ACQUIRE, err and timeout clear.
- ACQUIRE:
  - Waits for the first rise; the partial first period is not measured.
  - On rise -> TRACK, with counter=1 and good_cnt=0.
- TRACK:
  - On rise, period is updated.
  - If the period is good: good_cnt+1; on reaching LOCK_COUNT -> LOCKED, and locked goes 1 in the same cycle that state becomes LOCKED.
  - If the period is bad: err=1, good_cnt=0, stay in TRACK.
- LOCKED:
  - On rise with a good period: good_cnt saturating increment.
  - On rise with a bad period: err=1, locked=0, good_cnt=0 -> TRACK.
- Timeout (any of ACQUIRE/TRACK/LOCKED):
  - If the counter reaches 4*DIV_RATIO without rise: timeout=1, err=1, locked=0, good_cnt=0 -> ACQUIRE.
  - The counter is cleared.
  - err and timeout stay sticky (not cleared) on this re-entry.
- Simultaneous events:
  - rise and the timeout threshold in the same cycle: rise wins.
  - enable=0 in any state forces IDLE next cycle and drops locked immediately (registered, 1 cycle).
- Mid-operation:
  - resetn asserted mid-operation returns everything to reset values asynchronously.
  - No output glitches are permitted; all outputs are registered.

Test Plan:
- Nominal lock: resetn release, enable=1, divclk_in square wave period 8 (4 high/4 low) -> period=8 on each rise, good_cnt 1,2,3,4, locked=1 after 4th measured period, err=0.
- Bad period: after lock, insert one period of 10 (TOL=0) -> locked=0, err=1, good_cnt=0 at that rise; 4 further good periods -> locked=1 again, err stays 1.
- Tolerance: TOL=1, periods alternating 7/9 -> locked=1 after 4 periods, err=0; a period of 6 -> err=1.
- Stopped clock: hold divclk_in=0 after lock -> 32 cycles after last counter reload, timeout=1, err=1, locked=0; restart clock -> relock after first edge + 4 good periods.
- Enable/reset mid-run: enable=0 while LOCKED -> locked=0 next cycle, good_cnt=0; pulse resetn low for 1 cycle mid-TRACK -> all outputs 0 immediately, no lock until full re-qualification.
- Simultaneous: edge arriving exactly at counter=32 -> measured period 32, bad -> err=1, state TRACK, timeout stays 0.
